// File: rtl/cbrt.sv
`default_nettype none
// ============================================================================
// Module   : cbrt
// Purpose  : Iterative integer cube root, y = floor(cbrt(x)), for a 24-bit
//            unsigned operand. Digit-by-digit root (one result bit per
//            iteration, MSB first) using a bit-serial shift-add multiplier.
//            Fixed latency of 80 cycles from start edge to result.
// Ports    : clk_i   - clock, rising edge
//            rst_i   - asynchronous active-low reset
//            x_bi    - 24-bit operand, sampled on the start edge
//            start_i - launch request, honoured only while idle
//            busy_o  - high while a computation is in flight
//            y_bo    - 8-bit result, holds the last completed root
// Revision : 1.0 - initial release
// ============================================================================
module cbrt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] x_bi,
    input  logic        start_i,
    output logic        busy_o,
    output logic [7:0]  y_bo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        MUL  = 2'd2,
        CMP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] rem_q, rem_d;
    logic [7:0]  y_q, y_d;
    logic [2:0]  i_q, i_d;
    logic [7:0]  m_q, m_d;
    logic [7:0]  n_q, n_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  k_q, k_d;
    logic        busy_q, busy_d;
    logic [7:0]  yo_q, yo_d;

    // Partial product for the current multiplier bit.
    logic [15:0] w_madd;
    // Trial subtrahend b = (3*y*(y+1) + 1) << 3i, kept at full 42 bits so a
    // b that exceeds the 24-bit remainder can never wrap into a false match.
    logic [41:0] w_tri;
    logic [5:0]  w_shift;
    logic [41:0] w_b;
    logic        w_ge;
    logic [7:0]  w_ynext;

    assign w_madd  = {8'd0, m_q} << k_q;
    assign w_tri   = ({26'd0, acc_q} * 42'd3) + 42'd1;
    assign w_shift = {3'd0, i_q} * 6'd3;
    assign w_b     = w_tri << w_shift;
    assign w_ge    = ({18'd0, rem_q} >= w_b);
    assign w_ynext = w_ge ? (y_q + 8'd1) : y_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        y_d     = y_q;
        i_d     = i_q;
        m_d     = m_q;
        n_d     = n_q;
        acc_d   = acc_q;
        k_d     = k_q;
        yo_d    = yo_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_d   = x_bi;
                    y_d     = 8'd0;
                    i_d     = 3'd7;
                    state_d = PREP;
                end
            end
            PREP: begin
                // Shift in a zero digit; multiplier computes y*(y+1) for the
                // doubled y.
                y_d     = {y_q[6:0], 1'b0};
                m_d     = {y_q[6:0], 1'b0};
                n_d     = {y_q[6:0], 1'b1};
                acc_d   = 16'd0;
                k_d     = 3'd0;
                state_d = MUL;
            end
            MUL: begin
                if (n_q[k_q]) begin
                    acc_d = acc_q + w_madd;
                end
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = CMP;
                end
            end
            CMP: begin
                if (w_ge) begin
                    rem_d = rem_q - w_b[23:0];
                end
                y_d = w_ynext;
                if (i_q == 3'd0) begin
                    yo_d    = w_ynext;
                    state_d = IDLE;
                end else begin
                    i_d     = i_q - 3'd1;
                    state_d = PREP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rem_q   <= 24'd0;
            y_q     <= 8'd0;
            i_q     <= 3'd0;
            m_q     <= 8'd0;
            n_q     <= 8'd0;
            acc_q   <= 16'd0;
            k_q     <= 3'd0;
            busy_q  <= 1'b0;
            yo_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            y_q     <= y_d;
            i_q     <= i_d;
            m_q     <= m_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            yo_q    <= yo_d;
        end
    end

    assign busy_o = busy_q;
    assign y_bo   = yo_q;

endmodule
`default_nettype wire

// File: tb/tb_cbrt.sv
`default_nettype none
// ============================================================================
// Module   : tb_cbrt
// Purpose  : Self-checking bench for cbrt: reset/idle, directed roots,
//            boundary operands, start handshake, reset abort and a random
//            back-to-back sweep against a reference floor-cube-root.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cbrt;

    logic        clk_i;
    logic        rst_i;
    logic [23:0] x_bi;
    logic        start_i;
    logic        busy_o;
    logic [7:0]  y_bo;

    int errors;
    int checks;
    time last_e0;

    cbrt u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .x_bi    (x_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
        .y_bo    (y_bo)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_cbrt(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Launch one computation, hold start until busy is seen, count busy
    // cycles and check the result. Optionally pulse start mid-run with a
    // different operand (must be ignored).
    task automatic run_one(input string tag, input logic [23:0] x,
                           input int exp, input int pulse_at,
                           input logic [23:0] pulse_x, input bit chk_period);
        int cyc;
        logic [7:0] y_prev;
        logic [7:0] y_late;
        y_prev = y_bo;
        @(negedge clk_i);
        x_bi    = x;
        start_i = 1'b1;
        @(posedge clk_i);
        if (chk_period) check({tag, "_period"}, longint'($time - last_e0), 810);
        last_e0 = $time;
        #1;
        start_i = 1'b0;
        x_bi    = 24'hABCDEF;
        check({tag, "_busy_rise"}, busy_o, 1);
        cyc    = 0;
        y_late = y_prev;
        while (busy_o && cyc < 200) begin
            if (cyc == pulse_at) begin
                x_bi    = pulse_x;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            cyc++;
            if (cyc == 79) y_late = y_bo;
        end
        start_i = 1'b0;
        check({tag, "_hold"}, y_late, y_prev);
        check({tag, "_busy_cycles"}, cyc, 80);
        check({tag, "_y"}, y_bo, exp);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        last_e0 = 0;
        rst_i   = 1'b0;
        start_i = 1'b0;
        x_bi    = 24'd0;

        #1;
        check("rst_busy", busy_o, 0);
        check("rst_y", y_bo, 0);
        #20;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i);
            #1;
            check("idle_busy", busy_o, 0);
            check("idle_y", y_bo, 0);
        end

        run_one("x0",       24'd0,        0,   -1, 24'd0, 1'b0);
        run_one("x1",       24'd1,        1,   -1, 24'd0, 1'b0);
        run_one("x26",      24'd26,       2,   -1, 24'd0, 1'b0);
        run_one("x27",      24'd27,       3,   -1, 24'd0, 1'b0);
        run_one("x1e6",     24'd1000000,  100, -1, 24'd0, 1'b0);
        run_one("xmax",     24'd16777215, 255, -1, 24'd0, 1'b0);
        run_one("x255c",    24'd16581375, 255, -1, 24'd0, 1'b0);
        run_one("x255c_m1", 24'd16581374, 254, -1, 24'd0, 1'b0);

        // Handshake: mid-run start pulse with another operand is ignored.
        run_one("hs64", 24'd64, 4, 30, 24'd125, 1'b0);
        repeat (5) @(posedge clk_i);
        #1;
        check("hs_idle_busy", busy_o, 0);
        check("hs_idle_y", y_bo, 4);
        run_one("hs125", 24'd125, 5, -1, 24'd0, 1'b0);

        // Reset abort mid-computation.
        @(negedge clk_i);
        x_bi    = 24'd1000000;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (40) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        check("abort_busy", busy_o, 0);
        check("abort_y", y_bo, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("abort_idle_busy", busy_o, 0);
        run_one("after_abort", 24'd8, 2, -1, 24'd0, 1'b0);

        // Random back-to-back sweep.
        for (int t = 0; t < 500; t++) begin
            logic [23:0] xr;
            xr = 24'($urandom);
            run_one("rand", xr, ref_cbrt(int'(xr)), -1, 24'd0, t > 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cbrt.md
# cbrt

Iterative integer cube-root responder: computes y = floor(cbrt(x)) for a 24-bit unsigned operand. It is the inverse of the cube unit. It is a worker behind the same start/busy handshake the func-level controllers use to drive cube and sqrt, so a controller can launch it and poll it the same way. The datapath is a bit-serial digit-by-digit root with a shared shift-add multiplier. Fixed latency, no external memory.

## Interface
- No parameters. Widths are fixed: 24-bit operand, 8-bit result.
- clk_i  in  1  single clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-low reset. Low clears all state immediately, independent of clk_i.
- x_bi  in  24  unsigned operand. Sampled only on the start edge.
- start_i  in  1  request. Sampled in IDLE only.
- busy_o  out  1  high while a computation is in flight.
- y_bo  out  8  result register. Holds the last completed result.

## Operation
- Reset values: busy_o=0, y_bo=0, state=IDLE, all working registers 0.
- Algorithm, per iteration i = 7 down to 0, with s = 3*i:
  - y = 2*y
  - b = (3*y*(y+1) + 1) << s
  - if rem >= b: rem = rem - b, y = y + 1
- Initial values: rem = x, y = 0. After i=0, y_bo <= y.
- Compare width: b and rem are compared as 42-bit unsigned values. If b exceeds rem (including b ≥ 2^24), the bit is 0. No truncation of b is allowed.
- States:
  - IDLE: busy_o=0. If start_i=1, latch rem<=x_bi, y<=0, i<=7, go to PREP.
  - PREP: y<=2*y. Load multiplier operands m=2y, n=2y+1, acc=0, k=0. Go to MUL.
  - MUL: 8 cycles of shift-add (k=0..7): if n[k], acc += m<<k. After k=7, go to CMP.
  - CMP: form b from acc, then apply the compare/subtract/increment step.
    - If i=0: y_bo <= final y, go to IDLE.
    - Otherwise: i<=i-1, go to PREP.
- busy_o is a registered output equal to (state != IDLE).
- start_i outside IDLE is ignored. No queueing, no abort.
- y_bo changes only on the final CMP edge. It never shows partial results.
- If start_i is still high in the IDLE cycle after completion, a new computation starts with the current x_bi. Initiators must drop start_i once busy_o is seen.
- Changes to x_bi during busy do not affect the result.

## Timing
- The start edge (E0) is the edge that samples start_i=1 in IDLE.
- busy_o=1 from after E0 through E80. Each iteration takes 10 cycles (PREP 1, MUL 8, CMP 1), and there are 8 iterations.
- At E80: y_bo updates and busy_o falls, on the same edge.
- Earliest next start edge is E81.
- Throughput: 1 result per 81 cycles with back-to-back starts.
- Latency is data-independent, including x=0 and x=2^24-1.
- Reset low mid-computation:
  - busy_o=0, y_bo=0 immediately.
  - After release, the block is in IDLE and ignores the aborted request.
  - The first start_i sampled high after release launches normally.

## Test plan
- Reset then idle: rst_i low, release, start_i=0 for 20 cycles -> busy_o=0 and y_bo=0 throughout.
- Basic values:
  - x=0 -> 0; x=1 -> 1; x=26 -> 2; x=27 -> 3; x=1000000 -> 100.
  - Each: busy_o high exactly 80 cycles, y_bo updates on the falling-busy edge.
- Boundaries:
  - x=16777215 -> 255; x=16581375 -> 255; x=16581374 -> 254.
  - Confirms the 42-bit compare with no overflow.
- Handshake:
  - Pulse start_i with x=64 and hold it until busy_o seen, then change x_bi to 125 and pulse start_i again mid-run.
  - Required: result 4, second pulse ignored, y_bo still 4 until the next IDLE start.
  - Then start with x=125 -> 5.
- Reset abort:
  - Start x=1000000. Drop rst_i asynchronously mid-cycle at cycle 40.
  - Required: busy_o=0 and y_bo=0 before the next clock edge.
  - After release, start x=8 -> 2 in 80 cycles.
- Random sweep: 500 random 24-bit x against a reference model floor(cbrt(x)) with back-to-back starts -> all results match and period is 81 cycles.
